buyruk_sirala: RTL and testbench
================================

// Module: buyruk_sirala
// PURPOSE
//  Instruction sequencer that sits upstream of the bib3 ALU.
//  A small program is loaded into an internal instruction memory; on basla the block steps through it.
//  Each 9-bit buyruk {op[2:0], A[2:0], B[2:0]} is presented for BEKLE cycles.
//  The last ALU sonuc of each step is captured into son_sonuc.
// PARAMETERS
//  DERINLIK  16  instruction memory depth (words); power of two, >=2
//  BEKLE     3   cycles each instruction is held on buyruk; >=1
// PORTS
//  clk             in   1    single clock, rising edge
//  rst             in   1    asynchronous, active-high reset
//  yaz_en          in   1    memory write strobe
//  yaz_adres       in   $clog2(DERINLIK)    write address
//  yaz_veri        in   9    instruction word to write
//  uzunluk         in   $clog2(DERINLIK)+1  program length; sampled on basla
//  basla           in   1    start pulse
//  durdur          in   1    pause; freezes stepping while high
//  sonuc           in   4    result from the bib3 ALU
//  buyruk          out  9    current instruction to the ALU
//  buyruk_gecerli  out  1    buyruk is valid
//  sayac           out  $clog2(DERINLIK)   program counter
//  son_sonuc       out  4    ALU result captured at the end of the latest step
//  bitti           out  1    program finished
// BEHAVIOUR
//  - Reset (async, rst=1) values:
//    - FSM=BOS; sayac=0; hold counter=0.
//    - buyruk_gecerli=0; buyruk=0; son_sonuc=0; bitti=0; latched length=0.
//    - Memory contents are not reset. An unloaded word reads X.
//  - FSM states: BOS, CALIS, BITTI.
//  - Memory writes:
//    - Accepted in BOS and BITTI at the clk edge where yaz_en=1.
//    - Ignored in CALIS.
//  - BOS/BITTI + basla=1 at an edge:
//    - Latch L = min(uzunluk, DERINLIK); set sayac=0, hold counter=0, bitti=0.
//    - If L==0: go to BITTI with bitti=1, and buyruk_gecerli is never raised.
//    - Otherwise go to CALIS.
//  - Latency: first valid buyruk appears in the cycle after the basla edge.
//  - CALIS outputs:
//    - buyruk = mem[sayac] (combinational read).
//    - buyruk_gecerli = 1.
//    - Outside CALIS, buyruk = 0 and buyruk_gecerli = 0.
//  - CALIS stepping:
//    - The hold counter counts 0..BEKLE-1. durdur=1 freezes both the hold counter and sayac.
//    - At hold==BEKLE-1 with durdur=0, at that edge:
//      - son_sonuc <= sonuc.
//      - If sayac < L-1: sayac++ and hold counter=0.
//      - If sayac == L-1: end of program (see CONFIGURATION).
//  - basla during CALIS is ignored.
//  - bitti:
//    - Set on entry to BITTI and held until the next accepted basla.
//    - bitti and buyruk_gecerli are never both 1.
//  - Reset asserted mid-run: outputs drop asynchronously to their reset values. No step completes.
//  - Counters use wrap-free arithmetic. sayac never exceeds L-1.
// CONFIGURATION
//  - Macro BUYRUK_DONGU_EN.
//  - Defined: at the end of the program, sayac wraps to 0 and the block stays in CALIS.
//    - Runs until rst; BITTI is reached only via L==0.
//    - A basla in CALIS is still ignored.
//  - Undefined: at the end of the program, go to BITTI and set bitti=1.
// TESTING
//  1. Load mem[0..7] = 000_011_001, 001_011_001, 010_010_101, 011_010_101,
//     100_010_101, 101_010_101, 110_010_101, 111_010_101; uzunluk=8, basla
//     -> each word is on buyruk for exactly 3 cycles with gecerli=1, in order;
//        bitti=1 one cycle after the 24th valid cycle.
//  2. Drive sonuc = sayac+1 during the run
//     -> son_sonuc steps 1,2,...,8 at each step boundary; it ends at 8.
//  3. durdur=1 for 5 cycles during step 2
//     -> buyruk holds 001_011_001 for 8 cycles; sayac stays 1; total run is 29 cycles.
//  4. uzunluk=0, basla
//     -> BITTI next cycle, bitti=1, gecerli never 1.
//     uzunluk=20
//     -> clamps to L=16.
//  5. rst pulse at cycle 10 of a run
//     -> outputs immediately 0; a new basla restarts from sayac=0.
//     yaz_en in CALIS
//     -> memory unchanged.
//  6. BUYRUK_DONGU_EN defined, uzunluk=2
//     -> buyruk alternates mem[0], mem[1] every 3 cycles indefinitely; bitti stays 0.

Source files
------------

// File: rtl/buyruk_sirala.sv
// buyruk_sirala: instruction sequencer feeding the bib3 ALU.
// The program is loaded into a small instruction memory. A start pulse
// makes the block step through the program, holding each 9-bit word on
// buyruk for BEKLE cycles. The ALU result at the end of each step is
// captured in son_sonuc.
// Optional feature: define BUYRUK_DONGU_EN to loop the program forever
// instead of stopping in BITTI after the last word.
module buyruk_sirala #(
  parameter int DERINLIK = 16,
  parameter int BEKLE    = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          yaz_en,
  input  logic [$clog2(DERINLIK)-1:0]   yaz_adres,
  input  logic [8:0]                    yaz_veri,
  input  logic [$clog2(DERINLIK):0]     uzunluk,
  input  logic                          basla,
  input  logic                          durdur,
  input  logic [3:0]                    sonuc,
  output logic [8:0]                    buyruk,
  output logic                          buyruk_gecerli,
  output logic [$clog2(DERINLIK)-1:0]   sayac,
  output logic [3:0]                    son_sonuc,
  output logic                          bitti
);

  localparam int AW = $clog2(DERINLIK);
  localparam int LW = AW + 1;
  // Hold counter needs at least one bit even when BEKLE is 1.
  localparam int HW = (BEKLE > 1) ? $clog2(BEKLE) : 1;

  typedef enum logic [1:0] {BOS, CALIS, BITTI} durum_t;

  durum_t          durum_q, durum_d;
  logic [AW-1:0]   sayac_q, sayac_d;
  logic [HW-1:0]   bekle_q, bekle_d;
  logic [LW-1:0]   uzun_q,  uzun_d;
  logic [3:0]      son_q,   son_d;

  logic [8:0]      mem [DERINLIK];
  logic [LW-1:0]   uzun_kisit;
  logic            adim_son;
  logic            program_son;

  // Program length is clamped to the memory depth at start.
  assign uzun_kisit  = (uzunluk > LW'(DERINLIK)) ? LW'(DERINLIK) : uzunluk;
  assign adim_son    = (bekle_q == HW'(BEKLE - 1));
  // Compare in LW bits so L-1 never underflows.
  assign program_son = (({1'b0, sayac_q} + LW'(1)) >= uzun_q);

  // Instruction memory write port; the program is frozen while running.
  always_ff @(posedge clk) begin
    if (yaz_en && (durum_q != CALIS)) begin
      mem[yaz_adres] <= yaz_veri;
    end
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q <= BOS;
      sayac_q <= '0;
      bekle_q <= '0;
      uzun_q  <= '0;
      son_q   <= '0;
    end else begin
      durum_q <= durum_d;
      sayac_q <= sayac_d;
      bekle_q <= bekle_d;
      uzun_q  <= uzun_d;
      son_q   <= son_d;
    end
  end

  // Next-state logic: start handling, hold counting and step advance.
  always_comb begin
    durum_d = durum_q;
    sayac_d = sayac_q;
    bekle_d = bekle_q;
    uzun_d  = uzun_q;
    son_d   = son_q;
    unique case (durum_q)
      BOS, BITTI: begin
        if (basla) begin
          uzun_d  = uzun_kisit;
          sayac_d = '0;
          bekle_d = '0;
          durum_d = (uzun_kisit == '0) ? BITTI : CALIS;
        end
      end
      CALIS: begin
        if (!durdur) begin
          if (adim_son) begin
            son_d = sonuc;
            if (!program_son) begin
              sayac_d = sayac_q + AW'(1);
              bekle_d = '0;
            end else begin
`ifdef BUYRUK_DONGU_EN
              sayac_d = '0;
              bekle_d = '0;
`else
              durum_d = BITTI;
`endif
            end
          end else begin
            bekle_d = bekle_q + HW'(1);
          end
        end
      end
      default: durum_d = BOS;
    endcase
  end

  // Outputs: the current word is only presented while running.
  always_comb begin
    buyruk         = '0;
    buyruk_gecerli = 1'b0;
    if (durum_q == CALIS) begin
      buyruk         = mem[sayac_q];
      buyruk_gecerli = 1'b1;
    end
  end

  assign sayac     = sayac_q;
  assign son_sonuc = son_q;
  assign bitti     = (durum_q == BITTI);

endmodule

// File: tb/tb_buyruk_sirala.sv
// Directed testbench for buyruk_sirala (default build, or looping build
// when BUYRUK_DONGU_EN is defined).
module tb_buyruk_sirala;

  logic       clk = 1'b0;
  logic       rst;
  logic       yaz_en;
  logic [3:0] yaz_adres;
  logic [8:0] yaz_veri;
  logic [4:0] uzunluk;
  logic       basla;
  logic       durdur;
  logic [3:0] sonuc;
  logic [8:0] buyruk;
  logic       buyruk_gecerli;
  logic [3:0] sayac;
  logic [3:0] son_sonuc;
  logic       bitti;

  logic [8:0] prog [16];
  int n_pass  = 0;
  int n_total = 0;

  buyruk_sirala #(.DERINLIK(16), .BEKLE(3)) dut (
    .clk(clk), .rst(rst), .yaz_en(yaz_en), .yaz_adres(yaz_adres),
    .yaz_veri(yaz_veri), .uzunluk(uzunluk), .basla(basla), .durdur(durdur),
    .sonuc(sonuc), .buyruk(buyruk), .buyruk_gecerli(buyruk_gecerli),
    .sayac(sayac), .son_sonuc(son_sonuc), .bitti(bitti)
  );

  always #5 clk = ~clk;

  // The ALU stand-in returns sayac+1 so each step leaves a known result.
  always_comb sonuc = sayac + 4'd1;

  task automatic kontrol(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [4:0] len);
    uzunluk = len;
    basla   = 1'b1;
    tick();
    basla   = 1'b0;
  endtask

  task automatic bitti_bekle();
    int n;
    n = 0;
    while (!bitti && n < 200) begin
      tick();
      n++;
    end
    kontrol("bitti_timeout", 32'(bitti), 32'd1);
  endtask

  initial begin
    int c, n1, maxs, both;
    prog[0] = 9'b000_011_001; prog[1] = 9'b001_011_001;
    prog[2] = 9'b010_010_101; prog[3] = 9'b011_010_101;
    prog[4] = 9'b100_010_101; prog[5] = 9'b101_010_101;
    prog[6] = 9'b110_010_101; prog[7] = 9'b111_010_101;
    for (int i = 8; i < 16; i++) prog[i] = 9'(i * 3);

    rst = 1'b1; yaz_en = 1'b0; yaz_adres = '0; yaz_veri = '0;
    uzunluk = '0; basla = 1'b0; durdur = 1'b0;
    repeat (2) tick();
    kontrol("rst_gecerli", 32'(buyruk_gecerli), 32'd0);
    kontrol("rst_buyruk",  32'(buyruk),         32'd0);
    kontrol("rst_sayac",   32'(sayac),          32'd0);
    kontrol("rst_son",     32'(son_sonuc),      32'd0);
    kontrol("rst_bitti",   32'(bitti),          32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      yaz_en = 1'b1; yaz_adres = 4'(i); yaz_veri = prog[i];
      tick();
    end
    yaz_en = 1'b0;
    $display("program loaded");

`ifdef BUYRUK_DONGU_EN
    // Looping build: two-word program repeats with no end.
    start(5'd2);
    for (int k = 0; k < 18; k++) begin
      kontrol("dongu_buyruk",  32'(buyruk),         32'(prog[(k / 3) % 2]));
      kontrol("dongu_gecerli", 32'(buyruk_gecerli), 32'd1);
      kontrol("dongu_bitti",   32'(bitti),          32'd0);
      tick();
    end
    $display("loop run checked");
`else
    // Plain run of 8 words, 3 cycles each; son_sonuc tracks sayac+1.
    start(5'd8);
    for (int s = 0; s < 8; s++) begin
      for (int h = 0; h < 3; h++) begin
        kontrol("t1_gecerli", 32'(buyruk_gecerli), 32'd1);
        kontrol("t1_buyruk",  32'(buyruk),         32'(prog[s]));
        kontrol("t1_sayac",   32'(sayac),          32'(s));
        kontrol("t1_bitti",   32'(bitti),          32'd0);
        if (h == 0) kontrol("t2_son_sonuc", 32'(son_sonuc), 32'(s));
        tick();
      end
    end
    kontrol("t1_bitti_end",   32'(bitti),          32'd1);
    kontrol("t1_gecerli_end", 32'(buyruk_gecerli), 32'd0);
    kontrol("t1_buyruk_end",  32'(buyruk),         32'd0);
    kontrol("t2_son_end",     32'(son_sonuc),      32'd8);
    $display("run of 8 words checked");

    // Pause during step 2 for 5 cycles.
    start(5'd8);
    c = 1; n1 = 0;
    while (buyruk_gecerli && c <= 100) begin
      durdur = (c >= 4 && c <= 8);
      if (sayac == 4'd1) begin
        n1++;
        kontrol("t3_buyruk_hold", 32'(buyruk), 32'(prog[1]));
      end
      tick();
      c++;
    end
    durdur = 1'b0;
    kontrol("t3_run_len",  32'(c - 1),     32'd29);
    kontrol("t3_step2",    32'(n1),        32'd8);
    kontrol("t3_bitti",    32'(bitti),     32'd1);
    kontrol("t3_son",      32'(son_sonuc), 32'd8);
    $display("paused run checked");

    // Length 20 clamps to 16 words.
    start(5'd20);
    c = 1; maxs = 0; both = 0;
    while (buyruk_gecerli && c <= 200) begin
      if (int'(sayac) > maxs) maxs = int'(sayac);
      if (bitti) both++;
      tick();
      c++;
    end
    kontrol("t4_clamp_len", 32'(c - 1),     32'd48);
    kontrol("t4_clamp_max", 32'(maxs),      32'd15);
    kontrol("t4_both",      32'(both),      32'd0);
    kontrol("t4_bitti",     32'(bitti),     32'd1);
    kontrol("t4_son",       32'(son_sonuc), 32'd0);
    $display("clamped run checked");

    // Asynchronous reset in cycle 10 of a run.
    start(5'd8);
    repeat (9) tick();
    kontrol("t5_pre_gecerli", 32'(buyruk_gecerli), 32'd1);
    kontrol("t5_pre_sayac",   32'(sayac),          32'd3);
    #2 rst = 1'b1;
    #1;
    kontrol("t5_rst_gecerli", 32'(buyruk_gecerli), 32'd0);
    kontrol("t5_rst_buyruk",  32'(buyruk),         32'd0);
    kontrol("t5_rst_sayac",   32'(sayac),          32'd0);
    kontrol("t5_rst_son",     32'(son_sonuc),      32'd0);
    kontrol("t5_rst_bitti",   32'(bitti),          32'd0);
    #1 rst = 1'b0;
    tick();
    kontrol("t5_idle_gecerli", 32'(buyruk_gecerli), 32'd0);
    $display("mid-run reset checked");

    // Zero length from idle goes straight to BITTI.
    start(5'd0);
    kontrol("t4_zero_bitti", 32'(bitti), 32'd1);
    for (int k = 0; k < 3; k++) begin
      kontrol("t4_zero_gecerli", 32'(buyruk_gecerli), 32'd0);
      tick();
    end
    $display("zero-length start checked");

    // Restart from sayac 0; a write during the run must be dropped.
    start(5'd8);
    kontrol("t5_restart_sayac",   32'(sayac),          32'd0);
    kontrol("t5_restart_buyruk",  32'(buyruk),         32'(prog[0]));
    kontrol("t5_restart_gecerli", 32'(buyruk_gecerli), 32'd1);
    kontrol("t5_restart_bitti",   32'(bitti),          32'd0);
    yaz_en = 1'b1; yaz_adres = 4'd0; yaz_veri = 9'h1FF;
    tick();
    yaz_en = 1'b0;
    bitti_bekle();
    start(5'd1);
    kontrol("t5_mem_kept", 32'(buyruk), 32'(prog[0]));
    bitti_bekle();
    kontrol("t5_one_son", 32'(son_sonuc), 32'd1);
    $display("restart and write protection checked");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
